// File: rtl/tail_light_pkg.sv
// rtl/tail_light_pkg.sv - shared types and helpers for the tail-light sequencer
//
// Purpose: mode encoding visible on the sequencer's mode port, plus the
// thermometer mask used to fill a side's lamps from the inside out.
// Ports: none (package).

package tail_light_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_t;

  // Widest side the sequencer supports; callers size-cast the result down.
  localparam int MAX_LAMPS = 8;

  // Thermometer mask: step=k lights lamps 0..k-1, clipped to the lamp count.
  function automatic logic [MAX_LAMPS-1:0] fill_mask(input int step, input int lamps);
    logic [MAX_LAMPS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      if ((i < step) && (i < lamps)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running step-tick generator with synchronous clear
//
// Purpose: divides clk down to one tick every TICK_DIV cycles.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   clr   in   restart the count at 0 on the next edge
//   tick  out  high on the cycle the count sits at TICK_DIV-1

module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // With TICK_DIV=1 the count is pinned at 0 == LAST, so tick is always high.
  assign tick = (count == LAST);

endmodule

// File: rtl/tail_light_seq.sv
// rtl/tail_light_seq.sv - sweeping turn / hazard / brake tail-light sequencer
//
// Purpose: turns debounced switch levels into registered lamp drive patterns.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   left_req  in   left turn request (level)
//   right_req in   right turn request (level)
//   hazard    in   hazard request (level)
//   brake     in   brake pedal (level)
//   lamp_l    out  left lamps, bit 0 innermost
//   lamp_r    out  right lamps, bit 0 innermost
//   mode      out  current mode

module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             left_req,
  input  logic             right_req,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output mode_t            mode
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);

  mode_t            req;
  mode_t            mode_next;
  logic [SW-1:0]    step;
  logic [SW-1:0]    step_next;
  logic             haz_phase;
  logic             haz_next;
  logic             tick;
  logic             clr;
  logic [LAMPS-1:0] step_mask;
  logic [LAMPS-1:0] brake_mask;
  logic [LAMPS-1:0] haz_mask;
  logic [LAMPS-1:0] lamp_l_next;
  logic [LAMPS-1:0] lamp_r_next;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  // Effective request expressed as the mode it would select; IDLE means none.
  always_comb begin
    if (hazard || (left_req && right_req)) begin
      req = MODE_HAZ;
    end else if (left_req) begin
      req = MODE_LEFT;
    end else if (right_req) begin
      req = MODE_RIGHT;
    end else begin
      req = MODE_IDLE;
    end
  end

  always_comb begin
    mode_next = mode;
    step_next = (step > STEP_MAX) ? '0 : step;
    haz_next  = haz_phase;

    // IDLE reacts at once; active modes only re-evaluate on a step tick.
    if (((mode == MODE_IDLE) && (req != MODE_IDLE)) ||
        ((mode != MODE_IDLE) && tick && (req != mode))) begin
      mode_next = req;
      step_next = ((req == MODE_LEFT) || (req == MODE_RIGHT)) ? SW'(1) : '0;
      haz_next  = (req == MODE_HAZ);
    end else if ((mode != MODE_IDLE) && tick) begin
      if (mode == MODE_HAZ) begin
        haz_next = ~haz_phase;
      end else begin
        // Step LAMPS wraps to 0: one all-dark step before the sweep restarts.
        step_next = (step >= STEP_MAX) ? '0 : step + SW'(1);
      end
    end
  end

  // Restart the prescaler on every mode change so the first step lasts a full period.
  assign clr = (mode_next != mode);

  // Lamps are derived from next-state values so they update on the same edge as mode.
  always_comb begin
    step_mask   = LAMPS'(fill_mask(int'(step_next), LAMPS));
    brake_mask  = {LAMPS{brake}};
    haz_mask    = {LAMPS{haz_next}};
    lamp_l_next = brake_mask;
    lamp_r_next = brake_mask;
    case (mode_next)
      MODE_LEFT:  lamp_l_next = step_mask;
      MODE_RIGHT: lamp_r_next = step_mask;
      MODE_HAZ: begin
        lamp_l_next = haz_mask;
        lamp_r_next = haz_mask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= MODE_IDLE;
      step      <= '0;
      haz_phase <= 1'b0;
      lamp_l    <= '0;
      lamp_r    <= '0;
    end else begin
      mode      <= mode_next;
      step      <= step_next;
      haz_phase <= haz_next;
      lamp_l    <= lamp_l_next;
      lamp_r    <= lamp_r_next;
    end
  end

endmodule

// File: tb/tb_tail_light_seq.sv
// tb/tb_tail_light_seq.sv - self-checking bench for tail_light_seq

module tb_tail_light_seq;
  import tail_light_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       left_req, right_req, hazard, brake;
  logic [2:0] lamp_l, lamp_r;
  mode_t      mode;

  logic       left2, right2, hazard2, brake2;
  logic [4:0] lamp_l2, lamp_r2;
  mode_t      mode2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tail_light_seq #(.LAMPS(3), .TICK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .left_req  (left_req),
    .right_req (right_req),
    .hazard    (hazard),
    .brake     (brake),
    .lamp_l    (lamp_l),
    .lamp_r    (lamp_r),
    .mode      (mode)
  );

  tail_light_seq #(.LAMPS(5), .TICK_DIV(1)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .left_req  (left2),
    .right_req (right2),
    .hazard    (hazard2),
    .brake     (brake2),
    .lamp_l    (lamp_l2),
    .lamp_r    (lamp_r2),
    .mode      (mode2)
  );

  typedef struct {
    logic       l, r, h, b;
    logic [2:0] el, er;
    mode_t      em;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic l, input logic r, input logic h, input logic b,
                              input logic [2:0] el, input logic [2:0] er,
                              input mode_t em, input int n);
    vec_t v;
    v.l = l; v.r = r; v.h = h; v.b = b;
    v.el = el; v.er = er; v.em = em;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick_sample();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] exp5 [7];

  initial begin
    rst_n = 1'b0;
    left_req = 0; right_req = 0; hazard = 0; brake = 0;
    left2 = 0; right2 = 0; hazard2 = 0; brake2 = 0;

    // Entry k: inputs held before edge k+1, expected outputs after that edge.
    add(1,0,0,0, 3'b001, 3'b000, MODE_LEFT,  4);
    add(1,0,0,0, 3'b011, 3'b000, MODE_LEFT,  4);
    add(1,0,0,0, 3'b111, 3'b000, MODE_LEFT,  4);
    add(1,0,0,0, 3'b000, 3'b000, MODE_LEFT,  4);
    add(1,0,0,0, 3'b001, 3'b000, MODE_LEFT,  1);
    add(1,0,0,1, 3'b001, 3'b111, MODE_LEFT,  3);
    add(1,0,0,1, 3'b011, 3'b111, MODE_LEFT,  1);
    add(1,0,0,0, 3'b011, 3'b000, MODE_LEFT,  1);
    add(0,0,0,0, 3'b011, 3'b000, MODE_LEFT,  2);
    add(0,0,0,0, 3'b000, 3'b000, MODE_IDLE,  1);
    add(0,0,0,1, 3'b111, 3'b111, MODE_IDLE,  1);
    add(0,0,0,0, 3'b000, 3'b000, MODE_IDLE,  1);
    add(1,1,0,0, 3'b111, 3'b111, MODE_HAZ,   2);
    add(1,1,0,1, 3'b111, 3'b111, MODE_HAZ,   2);
    add(1,1,0,1, 3'b000, 3'b000, MODE_HAZ,   3);
    add(1,1,0,0, 3'b000, 3'b000, MODE_HAZ,   1);
    add(0,0,1,0, 3'b111, 3'b111, MODE_HAZ,   4);
    add(0,0,0,0, 3'b000, 3'b000, MODE_IDLE,  1);
    add(0,1,0,0, 3'b000, 3'b001, MODE_RIGHT, 4);
    add(0,1,0,0, 3'b000, 3'b011, MODE_RIGHT, 2);
    add(1,0,0,0, 3'b000, 3'b011, MODE_RIGHT, 2);
    add(1,0,0,0, 3'b001, 3'b000, MODE_LEFT,  1);
    add(0,0,0,0, 3'b001, 3'b000, MODE_LEFT,  3);
    add(0,0,0,0, 3'b000, 3'b000, MODE_IDLE,  1);

    exp5 = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000, 5'b00001};

    #12;
    check("reset lamp_l", 8'(lamp_l), 8'h00);
    check("reset lamp_r", 8'(lamp_r), 8'h00);
    check("reset mode",   8'(mode),   8'(MODE_IDLE));
    check("reset lamp_l5", 8'(lamp_l2), 8'h00);
    check("reset lamp_r5", 8'(lamp_r2), 8'h00);
    check("reset mode5",   8'(mode2),   8'(MODE_IDLE));

    tick_sample();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      left_req  = vecs[i].l;
      right_req = vecs[i].r;
      hazard    = vecs[i].h;
      brake     = vecs[i].b;
      tick_sample();
      check($sformatf("vec%0d lamp_l", i), 8'(lamp_l), 8'(vecs[i].el));
      check($sformatf("vec%0d lamp_r", i), 8'(lamp_r), 8'(vecs[i].er));
      check($sformatf("vec%0d mode", i),   8'(mode),   8'(vecs[i].em));
    end

    // Five lamps, a step every cycle.
    left2 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick_sample();
      check($sformatf("sweep5 step%0d lamp_l", k), 8'(lamp_l2), 8'(exp5[k]));
      check($sformatf("sweep5 step%0d lamp_r", k), 8'(lamp_r2), 8'h00);
      check($sformatf("sweep5 step%0d mode", k),   8'(mode2),   8'(MODE_LEFT));
    end

    // Reset mid-sweep, asserted and released away from clock edges.
    left_req = 1'b1;
    for (int k = 0; k < 6; k++) tick_sample();
    brake = 1'b1;
    tick_sample();
    check("pre-reset lamp_l", 8'(lamp_l), 8'h03);
    check("pre-reset lamp_r", 8'(lamp_r), 8'h07);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset lamp_l",  8'(lamp_l),  8'h00);
    check("async reset lamp_r",  8'(lamp_r),  8'h00);
    check("async reset mode",    8'(mode),    8'(MODE_IDLE));
    check("async reset lamp_l5", 8'(lamp_l2), 8'h00);
    check("async reset mode5",   8'(mode2),   8'(MODE_IDLE));
    tick_sample();
    check("held reset lamp_r", 8'(lamp_r), 8'h00);
    check("held reset mode",   8'(mode),   8'(MODE_IDLE));
    brake = 1'b0;
    #2;
    rst_n = 1'b1;
    tick_sample();
    check("post-reset lamp_l", 8'(lamp_l), 8'h01);
    check("post-reset mode",   8'(mode),   8'(MODE_LEFT));
    tick_sample();
    check("post-reset hold lamp_l", 8'(lamp_l), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
- Parametrised tail-light sequencer: LAMPS lamps per side, left/right sweeping turn signals, hazard flasher, brake overlay.
- All lamp changes are paced by an internal prescaled step tick, not by the raw clock.
- Sits between the debounced switch inputs and the lamp drivers on the board top level.
- Outputs are registered and glitch-free.

Parameters:
- LAMPS, 3, lamps per side (2..8); bit 0 is the innermost lamp.
- TICK_DIV, 4, clock cycles per sequencer step (>=1; 1 means a step every cycle).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- left_req  in  1  left turn request (level).
- right_req  in  1  right turn request (level).
- hazard  in  1  hazard request (level).
- brake  in  1  brake pedal (level).
- lamp_l  out  LAMPS  left lamps; bit 0 is innermost.
- lamp_r  out  LAMPS  right lamps; bit 0 is innermost.
- mode  out  2  current mode (mode_t): IDLE, LEFT, RIGHT, HAZ.

Behaviour:
- Reset (async, rst_n=0): mode=IDLE, step=0, prescaler=0, haz_phase=0, lamp_l=lamp_r=0. Releasing reset is synchronous to clk.
- Effective request, highest priority first:
  - HAZ if hazard, or (left_req and right_req).
  - LEFT if left_req only.
  - RIGHT if right_req only.
  - NONE otherwise.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 on the cycle the count is TICK_DIV-1. It is cleared to 0 on every mode change.
- From IDLE: a non-NONE request is acted on at the next clk edge, with no wait for tick.
  - LEFT/RIGHT enter with step=1.
  - HAZ enters with haz_phase=1.
  - The prescaler is cleared, so the next step follows exactly TICK_DIV cycles later.
- LEFT/RIGHT, evaluated only on tick:
  - Request unchanged: step advances 1..LAMPS, then wraps to 0 (all off for one step), then 1 again.
  - Request switches to the other side: go to that side with step=1.
  - Request becomes HAZ: go to HAZ with haz_phase=1.
  - Request becomes NONE: go to IDLE, step=0.
- Requests changing between ticks are ignored until the next tick.
- HAZ: haz_phase toggles on each tick while the request is HAZ. On a tick where the request is LEFT/RIGHT/NONE, go to that mode as described above (step=1 or IDLE).
- Lamp outputs are registered and computed from the next-state values, so lamps reflect the new state on the same edge as the mode update:
  - Active side in LEFT/RIGHT: the lowest `step` bits are set, so step=k lights lamps 0..k-1 (fills inner to outer).
  - HAZ: both sides all ones when haz_phase=1, all zeros when haz_phase=0. Brake is ignored in HAZ.
  - Non-active side (IDLE, or the opposite side in LEFT/RIGHT): all ones if brake=1, else zeros.
  - brake is sampled every clk, not only on tick, so its effect appears one cycle after it changes.
- step register width: $clog2(LAMPS+1). Step never exceeds LAMPS; an illegal value is forced to 0.
- Reset mid-sequence: lamps go to 0 immediately (asynchronously). No sequence state survives reset.

Decomposition:
- Package tail_light_pkg: typedef enum logic[1:0] mode_t {MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZ}, plus a function fill_mask(step, LAMPS) returning the thermometer mask.
- Sub-module tick_prescaler (parameter TICK_DIV; ports clk, rst_n, clr, tick).
- The FSM, step counter and lamp output registers live in tail_light_seq.

Test Plan:
- Left sweep (LAMPS=3, TICK_DIV=4): assert left_req at cycle 0.
  - Required: lamp_l=001 from cycle 1, 011 at cycle 5, 111 at cycle 9, 000 at cycle 13, 001 at cycle 17.
  - lamp_r=000 throughout; mode=LEFT.
- Release mid-sweep: left_req high, dropped at lamp_l=011.
  - Required: lamp_l holds 011 until the next tick, then becomes 000 with mode=IDLE.
- Side switch: in RIGHT with lamp_r=011, change to left_req only.
  - Required: at the next tick lamp_r=000 and lamp_l=001, mode=LEFT.
- Hazard: assert left_req and right_req together from IDLE.
  - Required: mode=HAZ; both sides 111 for cycles 1-4, 000 for cycles 5-8, 111 for cycles 9-12.
  - Asserting brake during HAZ changes nothing.
- Brake overlay: in LEFT sweep, assert brake.
  - Required: lamp_r=111 one cycle later while lamp_l keeps sweeping; in IDLE, brake gives 111/111.
- Reset + parameter sweep: pulse rst_n low mid-sweep, not aligned to clk.
  - Required: both lamps 000 immediately and mode=IDLE.
  - Repeat the sweep scenario with LAMPS=5, TICK_DIV=1: lamp_l steps 00001, 00011, …, 11111, 00000 on consecutive cycles.
